input_buffer_12: RTL and testbench

INPUT_BUFFER_12 -- requirements
Module: input_buffer_12

---
 rtl/input_buffer_12_if.sv | 23 ++
 rtl/input_buffer_12.sv | 55 +++++
 tb/tb_input_buffer_12.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/input_buffer_12_if.sv
// input_buffer_12_if: flit handshake and status bundle between upstream link, buffer and routing stage
interface input_buffer_12_if #(
  parameter int DATASIZE = 40,
  parameter int WIDTH = 3
);
  logic [DATASIZE-1:0] data_in;
  logic valid_in;
  logic ready_out;
  logic [DATASIZE-1:0] data_out;
  logic valid_out;
  logic rc_ready;
  logic [WIDTH:0] pressure_out;
  logic almost_full;
  logic proto_err;
  modport master (
    output data_in, valid_in, rc_ready,
    input ready_out, data_out, valid_out, pressure_out, almost_full, proto_err
  );
  modport slave (
    input data_in, valid_in, rc_ready,
    output ready_out, data_out, valid_out, pressure_out, almost_full, proto_err
  );
endinterface

// File: rtl/input_buffer_12.sv
// input_buffer_12: first-word-fall-through flit FIFO with congestion pressure, almost-full flag and packet-sequence checking
// ports: rc_clk; rst (async, active-high); bus.slave carries data_in/valid_in/ready_out upstream, data_out/valid_out/rc_ready downstream, pressure_out/almost_full/proto_err status
module input_buffer_12 #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int DATASIZE = 40
) (
  input logic rc_clk,
  input logic rst,
  input_buffer_12_if.slave bus
);
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t st, st_nx;
  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_ptr, rd_ptr;
  logic [WIDTH:0] count, count_nx;
  logic [1:0] ty;
  logic wr, rd, err, af, pe;
  assign bus.ready_out = count != (WIDTH+1)'(DEPTH);
  assign bus.valid_out = count != '0;
  assign bus.data_out = mem[rd_ptr];
  assign bus.pressure_out = count;
  assign bus.almost_full = af;
  assign bus.proto_err = pe;
  assign wr = bus.valid_in && bus.ready_out;
  assign rd = bus.valid_out && bus.rc_ready;
  // packet checker looks at the flit leaving the FIFO: 00 single, 01 head, 10 body, 11 tail
  always_comb begin
    ty = bus.data_out[DATASIZE-1 -: 2];
    count_nx = count + (WIDTH+1)'(wr) - (WIDTH+1)'(rd);
    st_nx = st == IDLE ? (ty == 2'b01 ? IN_PKT : IDLE) : (ty == 2'b11 ? IDLE : IN_PKT);
    err = st == IDLE ? ty[1] : !ty[1];
  end
  always_ff @(posedge rc_clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      af <= 1'b0;
      pe <= 1'b0;
      st <= IDLE;
    end else begin
      count <= count_nx;
      af <= count_nx >= (WIDTH+1)'(DEPTH-2);
      if (wr) wr_ptr <= wr_ptr + WIDTH'(1);
      if (rd) begin
        rd_ptr <= rd_ptr + WIDTH'(1);
        st <= st_nx;
        pe <= pe | err;
      end
    end
  // storage is deliberately left out of reset
  always_ff @(posedge rc_clk)
    if (wr) mem[wr_ptr] <= bus.data_in;
endmodule

// File: tb/tb_input_buffer_12.sv
// tb_input_buffer_12: directed stimulus against a queue-based model of the flit buffer
module tb_input_buffer_12;
  logic rc_clk = 1'b0;
  logic rst = 1'b1;
  input_buffer_12_if bus();
  input_buffer_12 dut(.rc_clk(rc_clk), .rst(rst), .bus(bus));
  always #5 rc_clk = ~rc_clk;
  int vectors = 0;
  int miscompares = 0;
  logic [39:0] q[$];
  bit open_pkt = 1'b0;
  bit m_err = 1'b0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [39:0] flit(logic [1:0] t, int v);
    return {t, 38'(v)};
  endfunction
  task automatic step(logic v, logic [39:0] d, logic r);
    bus.valid_in = v;
    bus.data_in = d;
    bus.rc_ready = r;
    @(negedge rc_clk);
  endtask
  initial forever begin
    logic [39:0] f;
    bit do_rd, do_wr;
    @(posedge rc_clk or posedge rst);
    if (rst) begin
      q.delete();
      open_pkt = 1'b0;
      m_err = 1'b0;
    end else begin
      do_rd = bus.rc_ready && q.size() > 0;
      do_wr = bus.valid_in && q.size() < 8;
      if (do_rd) begin
        f = q.pop_front();
        case (f[39:38])
          2'd0: if (open_pkt) m_err = 1'b1;
          2'd1: begin if (open_pkt) m_err = 1'b1; open_pkt = 1'b1; end
          2'd2: if (!open_pkt) m_err = 1'b1;
          2'd3: begin if (!open_pkt) m_err = 1'b1; open_pkt = 1'b0; end
        endcase
      end
      if (do_wr) q.push_back(bus.data_in);
    end
  end
  initial forever begin
    @(negedge rc_clk);
    chk("valid_out", bus.valid_out, q.size() != 0);
    chk("ready_out", bus.ready_out, q.size() != 8);
    chk("pressure_out", bus.pressure_out, q.size());
    chk("almost_full", bus.almost_full, q.size() >= 6);
    chk("proto_err", bus.proto_err, m_err);
    if (q.size() != 0) chk("data_out", bus.data_out, q[0]);
  end
  initial begin
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.rc_ready = 1'b0;
    repeat (2) @(negedge rc_clk);
    chk("rst_pressure", bus.pressure_out, 0);
    chk("rst_ready", bus.ready_out, 1);
    chk("rst_valid", bus.valid_out, 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, flit(2'd0, i), 1'b0);
      chk("fill_pressure", bus.pressure_out, i);
      chk("fill_af", bus.almost_full, i >= 6);
      if (i == 1) chk("latency_data", bus.data_out, flit(2'd0, 1));
    end
    chk("full_ready", bus.ready_out, 0);
    step(1'b1, flit(2'd0, 9), 1'b0);
    chk("ninth_rejected", bus.pressure_out, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", bus.data_out, flit(2'd0, i));
      step(1'b0, '0, 1'b1);
      chk("drain_pressure", bus.pressure_out, 8 - i);
    end
    chk("empty_valid", bus.valid_out, 0);
    step(1'b0, '0, 1'b1);
    chk("empty_no_underflow", bus.pressure_out, 0);
    for (int i = 0; i < 3; i++) step(1'b1, flit(2'd0, 'h10 + i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_data", bus.data_out, flit(2'd0, 'h10 + i));
      step(1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 4; i++) step(1'b1, flit(2'd0, 'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("simul_data", bus.data_out, flit(2'd0, 'h20 + i));
      step(1'b1, flit(2'd0, 'h24 + i), 1'b1);
      chk("simul_pressure", bus.pressure_out, 4);
    end
    repeat (4) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, flit(2'd0, 'h30 + i), 1'b0);
    step(1'b1, flit(2'd0, 'h40), 1'b1);
    chk("fullrd_pressure", bus.pressure_out, 7);
    chk("fullrd_ready", bus.ready_out, 1);
    step(1'b1, flit(2'd0, 'h41), 1'b0);
    chk("fullrd_refill", bus.pressure_out, 8);
    repeat (7) step(1'b0, '0, 1'b1);
    chk("fullrd_last", bus.data_out, flit(2'd0, 'h41));
    step(1'b0, '0, 1'b1);
    step(1'b1, flit(2'd1, 'h60), 1'b0);
    step(1'b1, flit(2'd2, 'h61), 1'b0);
    step(1'b1, flit(2'd3, 'h62), 1'b0);
    step(1'b1, flit(2'd2, 'h63), 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1);
      chk("proto_stray_body", bus.proto_err, k == 3);
    end
    step(1'b0, '0, 1'b0);
    chk("proto_sticky", bus.proto_err, 1);
    for (int i = 0; i < 5; i++) step(1'b1, flit(2'd0, 'h70 + i), 1'b0);
    chk("pre_rst_pressure", bus.pressure_out, 5);
    @(posedge rc_clk);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", bus.valid_out, 0);
    chk("async_pressure", bus.pressure_out, 0);
    chk("async_ready", bus.ready_out, 1);
    chk("async_proto", bus.proto_err, 0);
    chk("async_af", bus.almost_full, 0);
    @(negedge rc_clk);
    rst = 1'b0;
    step(1'b1, flit(2'd0, 'h50), 1'b0);
    chk("resume_pressure", bus.pressure_out, 1);
    chk("resume_data", bus.data_out, flit(2'd0, 'h50));
    step(1'b1, flit(2'd1, 'h51), 1'b0);
    step(1'b1, flit(2'd1, 'h52), 1'b0);
    step(1'b1, flit(2'd3, 'h53), 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1);
      chk("proto_double_head", bus.proto_err, k >= 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
